// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one SDRAM port among COUNT cores. Grants are
// non-preemptive, separated by one dead turnaround cycle, and carry a yield hint once the quantum is reached.
module mem_rr_arb #(
    parameter int COUNT   = 4,
    parameter int QUANTUM = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [COUNT-1:0]         request,
    output logic [COUNT-1:0]         authorized,
    output logic [COUNT-1:0]         yield,
    output logic [$clog2(COUNT)-1:0] owner,
    output logic                     busy
);
    localparam int OW = $clog2(COUNT);
    localparam int HW = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {IDLE, GRANTED, TURNAROUND} state_t;

    state_t           state, state_n;
    logic [OW-1:0]    last_owner, last_n, owner_n, winner;
    logic [HW-1:0]    hold_count, hold_n;
    logic [COUNT-1:0] auth_n, yield_n;
    logic             found;
    logic [OW:0]      cand;

    // Rotating priority: last_owner+1 is tried first, last_owner itself last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= COUNT; i++) begin
            cand = {1'b0, last_owner} + (OW+1)'(i);
            if (cand >= (OW+1)'(COUNT))
                cand = cand - (OW+1)'(COUNT);
            if (!found && request[cand[OW-1:0]]) begin
                found  = 1'b1;
                winner = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        auth_n  = authorized;
        owner_n = owner;
        last_n  = last_owner;
        hold_n  = hold_count;
        yield_n = '0;
        case (state)
            IDLE, TURNAROUND: begin
                state_n = IDLE;
                if (found) begin
                    state_n = GRANTED;
                    auth_n  = COUNT'(1) << winner;
                    owner_n = winner;
                    hold_n  = '0;
                end
            end
            GRANTED: begin
                if (request[owner]) begin
                    if (hold_count != HW'(QUANTUM))
                        hold_n = hold_count + HW'(1);
                    // Hint only while someone else is actually waiting.
                    if (hold_count == HW'(QUANTUM) && |(request & ~authorized))
                        yield_n[owner] = 1'b1;
                end else begin
                    state_n = TURNAROUND;
                    auth_n  = '0;
                    owner_n = '0;
                    last_n  = owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            authorized <= '0;
            yield      <= '0;
            owner      <= '0;
            last_owner <= OW'(COUNT - 1);
            hold_count <= '0;
        end else begin
            state      <= state_n;
            authorized <= auth_n;
            yield      <= yield_n;
            owner      <= owner_n;
            last_owner <= last_n;
            hold_count <= hold_n;
        end
    end

    assign busy = |authorized;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Self-checking bench for mem_rr_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_mem_rr_arb;
    localparam int N   = 4;
    localparam int Q   = 8;
    localparam int OWW = $clog2(N);

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   request = '0;
    logic [N-1:0]   authorized;
    logic [N-1:0]   yield;
    logic [OWW-1:0] owner;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_rr_arb #(.COUNT(N), .QUANTUM(Q)) dut (
        .clock(clock), .reset_n(reset_n), .request(request),
        .authorized(authorized), .yield(yield), .owner(owner), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Behavioural model: owner index or -1, the core that last held the bus,
    // cycles held (saturating), and the registered yield hint.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_hold  = 0;
    bit m_yield = 1'b0;

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (req[c[OWW-1:0]]) return c;
        end
        return -1;
    endfunction

    always @(negedge reset_n) begin
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_yield = 1'b0;
    end

    always @(posedge clock) begin
        logic [N-1:0] others;
        int p;
        if (reset_n) begin
            if (m_owner >= 0) begin
                if (request[m_owner[OWW-1:0]]) begin
                    others  = request & ~(N'(1) << m_owner);
                    m_yield = (m_hold == Q) && (others != 0);
                    if (m_hold < Q) m_hold++;
                end else begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_yield = 1'b0;
                end
            end else begin
                m_yield = 1'b0;
                p = rr_pick(m_last, request);
                if (p >= 0) begin
                    m_owner = p;
                    m_hold  = 0;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clock) begin
        int exp_auth;
        exp_auth = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("model_authorized", int'(authorized), exp_auth);
        chk("model_owner", int'(owner), (m_owner >= 0) ? m_owner : 0);
        chk("model_yield", int'(yield), m_yield ? exp_auth : 0);
        chk("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    end

    initial begin
        int grants[$];
        int held, zeros;
        logic [N-1:0] prev;
        int expy;

        // Reset with requests present: nothing may be granted.
        request = 4'b1111;
        tick(); tick();
        chk("rst_auth", int'(authorized), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_yield", int'(yield), 0);
        chk("rst_busy", int'(busy), 0);

        // First contention after reset.
        reset_n = 1'b1;
        request = 4'b1010;
        tick();
        chk("first_auth", int'(authorized), 4'b0010);
        chk("first_owner", int'(owner), 1);

        // Core1 drops, core3 waiting: one dead cycle then core3.
        request = 4'b1000;
        tick();
        chk("turn_auth", int'(authorized), 0);
        tick();
        chk("c3_auth", int'(authorized), 4'b1000);
        chk("c3_owner", int'(owner), 3);
        request = 4'b0000;
        tick(); tick();
        chk("idle_auth", int'(authorized), 0);

        // All cores request, each releasing after holding three cycles.
        grants.delete();
        held = 0; zeros = 0; prev = '0;
        request = 4'b1111;
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            tick();
            if (authorized == '0) begin
                zeros++;
                held = 0;
                request = 4'b1111;
            end else begin
                if (authorized != prev) begin
                    grants.push_back(int'(owner));
                    if (grants.size() > 1) chk("rr_gap", zeros, 1);
                    zeros = 0;
                    held = 1;
                end else begin
                    held++;
                end
                request = (held >= 3) ? (4'b1111 & ~authorized) : 4'b1111;
            end
            prev = authorized;
        end
        chk("rr_count", grants.size(), 5);
        if (grants.size() == 5) begin
            chk("rr_g0", grants[0], 0);
            chk("rr_g1", grants[1], 1);
            chk("rr_g2", grants[2], 2);
            chk("rr_g3", grants[3], 3);
            chk("rr_g4", grants[4], 0);
        end
        request = 4'b0000;
        tick(); tick(); tick();

        // Core2 holds long; core0 waits, withdraws, re-requests.
        request = 4'b0100;
        tick();
        chk("hold_auth0", int'(authorized), 4'b0100);
        chk("hold_owner0", int'(owner), 2);
        for (int c = 1; c <= 19; c++) begin
            tick();
            expy = ((c >= 9 && c <= 12) || c >= 15) ? 4'b0100 : 0;
            chk($sformatf("hold_yield_c%0d", c), int'(yield), expy);
            chk($sformatf("hold_auth_c%0d", c), int'(authorized), 4'b0100);
            if (c == 1)  request = 4'b0101;
            if (c == 12) request = 4'b0100;
            if (c == 14) request = 4'b0101;
            if (c == 19) request = 4'b0001;
        end
        tick();
        chk("rel_auth", int'(authorized), 0);
        chk("rel_yield", int'(yield), 0);
        tick();
        chk("next_auth", int'(authorized), 4'b0001);
        chk("next_owner", int'(owner), 0);

        // Async reset pulse between edges while core0 owns the bus.
        #1 reset_n = 1'b0;
        #1;
        chk("async_auth", int'(authorized), 0);
        chk("async_busy", int'(busy), 0);
        #1 reset_n = 1'b1;
        request = 4'b1111;
        tick();
        chk("post_rst_auth", int'(authorized), 4'b0001);
        chk("post_rst_owner", int'(owner), 0);

        // Randomized traffic: slow toggles give long holds and quantum hits.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) request[b] = ~request[b];
            if ($urandom_range(0, 499) == 0) begin
                #1 reset_n = 1'b0;
                #1;
                chk("rand_async_auth", int'(authorized), 0);
                #1 reset_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_rr_arb.md
MEM_RR_ARB -- requirements
Module: mem_rr_arb

Interface
- REQ-001 SHALL have parameter COUNT, default 4: number of cores sharing one SDRAM port; legal range 2..16.
- REQ-002 SHALL have parameter QUANTUM, default 64: number of owned cycles before a yield is requested; legal range 1..65535.
- REQ-003 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
- REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port request, input, COUNT: per-core request, held high for the whole memory use.
- REQ-006 SHALL have port authorized, output, COUNT: registered, one-hot-or-zero grant; a core SHALL NOT access memory unless its bit is high.
- REQ-007 SHALL have port yield, output, COUNT: registered; asks the current owner to finish and drop request.
- REQ-008 SHALL have port owner, output, $clog2(COUNT): index of the granted core; 0 when idle.
- REQ-009 SHALL have port busy, output, 1: high when authorized is nonzero.

Function
- REQ-010 SHALL implement three states: IDLE, GRANTED and TURNAROUND.
- REQ-011 In IDLE with request nonzero at an edge, SHALL set authorized to the round-robin winner at that edge (1-cycle latency) and enter GRANTED.
- REQ-012 Round-robin winner SHALL be the first requesting index, searching upward from last_owner+1 and wrapping modulo COUNT.
- REQ-013 Round-robin search SHALL include last_owner itself as the final candidate.
- REQ-014 In GRANTED, while request[owner] is high, authorized SHALL hold unchanged; no preemption, regardless of other requests or quantum.
- REQ-015 In GRANTED, at the edge sampling request[owner] low, SHALL clear authorized and yield, record last_owner = owner, and enter TURNAROUND.
- REQ-016 TURNAROUND SHALL last exactly one cycle with authorized zero, guaranteeing one dead bus cycle between owners.
- REQ-017 On leaving TURNAROUND, SHALL go to GRANTED with the new winner if any request is high, otherwise to IDLE.
- REQ-018 hold_count SHALL reset to 0 on each new grant, increment each GRANTED cycle, and saturate at QUANTUM (width $clog2(QUANTUM+1)).
- REQ-019 yield[owner] SHALL be registered high on each edge where hold_count equals QUANTUM and (request & ~authorized) is nonzero.
- REQ-020 yield[owner] SHALL be registered low on any edge where either condition of REQ-019 fails.
- REQ-021 All yield bits other than yield[owner] SHALL always be 0.
- REQ-022 A request pulse from a non-owner SHALL NOT be latched; only a request still high at a grant decision counts.
- REQ-023 Simultaneous owner release and new requests SHALL still pass through TURNAROUND; the grant follows REQ-012.
- REQ-024 owner SHALL equal the index of the set bit of authorized; busy SHALL equal |authorized.

Reset
- REQ-025 On reset_n low, immediately (asynchronously), SHALL set authorized=0, yield=0, owner=0, busy=0, state=IDLE, hold_count=0 and last_owner=COUNT-1.
- REQ-026 Because last_owner resets to COUNT-1, core 0 SHALL win the first contention after reset.
- REQ-027 Reset asserted mid-grant SHALL drop authorization in the same cycle without waiting for a clock edge.
- REQ-028 After reset_n deasserts, the first grant SHALL occur no earlier than the first rising edge after deassertion.

Verification (COUNT=4, QUANTUM=8)
- REQ-029 Bench SHALL cover: reset, then request=4'b1010 at edge 0 -> authorized=4'b0010 and owner=1 after edge 0.
- REQ-030 Bench SHALL cover: core1 drops request while request=4'b1000 -> one cycle with authorized=0, then authorized=4'b1000 and owner=3.
- REQ-031 Bench SHALL cover: all four cores request continuously, each releasing after 3 cycles -> grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- REQ-032 Bench SHALL cover: core2 holds for 20 cycles while core0 requests from cycle 2 -> yield=4'b0100 from cycle 9 after grant, authorized unchanged until core2 releases.
- REQ-033 Bench SHALL cover: with core2 yielding, core0 withdraws its request -> yield returns to 0 on the next edge.
- REQ-034 Bench SHALL cover: reset_n pulsed low between edges while authorized=4'b0001 -> authorized=0 immediately, and after release, request=4'b1111 -> authorized=4'b0001.
